// File: rtl/coin_pkg.sv
// Shared constants and helpers for the coin tally datapath.
// Optional debounce is enabled by defining COIN_TALLY_DEBOUNCE_EN.
package coin_pkg;

    localparam int COUNT_W     = 7;
    localparam int MAX_COUNT   = 127;
    localparam int DISPLAY_MAX = 99;

    localparam int PENNY_C   = 1;
    localparam int NICKEL_C  = 5;
    localparam int DIME_C    = 10;
    localparam int QUARTER_C = 25;

    localparam int NUM_COINS = 4;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_PENNY,
        SEL_NICKEL,
        SEL_DIME,
        SEL_QUARTER
    } coin_sel_e;

    // Coin value at the one-bit-wider adder width so overflow past MAX_COUNT is visible.
    function automatic logic [COUNT_W:0] coin_value(input coin_sel_e sel);
        case (sel)
            SEL_QUARTER: return (COUNT_W+1)'(QUARTER_C);
            SEL_DIME:    return (COUNT_W+1)'(DIME_C);
            SEL_NICKEL:  return (COUNT_W+1)'(NICKEL_C);
            SEL_PENNY:   return (COUNT_W+1)'(PENNY_C);
            default:     return '0;
        endcase
    endfunction

endpackage

// File: rtl/coin_edge.sv
// One coin channel: 2-flop synchronizer, optional debounce, rising-edge detector.
// Debounce filter exists only when COIN_TALLY_DEBOUNCE_EN is defined.
module coin_edge
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q, hist_d;
    logic clean;

`ifdef COIN_TALLY_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
`ifdef COIN_TALLY_DEBOUNCE_EN
        db_d  = db_q;
        cnt_d = '0;
        // Count clocks the synchronized level has differed from the accepted one;
        // any return to the accepted level restarts the count.
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        clean = db_q;
`else
        clean = sync2_q;
`endif
        hist_d = clean;
    end

    assign rise = clean & ~hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
`ifdef COIN_TALLY_DEBOUNCE_EN
            db_q    <= 1'b0;
            cnt_q   <= '0;
`endif
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
`ifdef COIN_TALLY_DEBOUNCE_EN
            db_q    <= db_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: rtl/coin_tally.sv
// Coin tally: per-coin pending bits, priority consume, saturating 7-bit cent total.
// Define COIN_TALLY_DEBOUNCE_EN to add the per-channel debounce filter.
module coin_tally
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [3:0]         coin_in,
    input  logic               clear,
    output logic [COUNT_W-1:0] SW,
    output logic               gt99,
    output logic               sat,
    output logic               upd
);

    logic [NUM_COINS-1:0] rise;

    for (genvar i = 0; i < NUM_COINS; i++) begin : g_chan
        coin_edge #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_edge (
            .clk  (CLOCK_50),
            .rst  (reset),
            .din  (coin_in[i]),
            .rise (rise[i])
        );
    end

    logic [NUM_COINS-1:0] pend_q, pend_d;
    logic [COUNT_W-1:0]   sw_q, sw_d;
    logic                 sat_q, sat_d;
    logic                 gt99_q, gt99_d;
    logic                 upd_q, upd_d;

    coin_sel_e            sel;
    logic [NUM_COINS-1:0] consume;
    logic [COUNT_W:0]     sum;

    always_comb begin
        sel     = SEL_NONE;
        consume = '0;
        if (pend_q[3]) begin
            sel     = SEL_QUARTER;
            consume = 4'b1000;
        end else if (pend_q[2]) begin
            sel     = SEL_DIME;
            consume = 4'b0100;
        end else if (pend_q[1]) begin
            sel     = SEL_NICKEL;
            consume = 4'b0010;
        end else if (pend_q[0]) begin
            sel     = SEL_PENNY;
            consume = 4'b0001;
        end

        sum    = {1'b0, sw_q} + coin_value(sel);
        sw_d   = sw_q;
        sat_d  = sat_q;
        // A fresh edge on a still-pending coin merges into the same bit and is lost.
        pend_d = (pend_q & ~consume) | rise;

        if (sel != SEL_NONE) begin
            if (sw_q == COUNT_W'(MAX_COUNT)) begin
                sat_d = 1'b1;
            end else if (sum > (COUNT_W+1)'(MAX_COUNT)) begin
                sw_d  = COUNT_W'(MAX_COUNT);
                sat_d = 1'b1;
            end else begin
                sw_d = sum[COUNT_W-1:0];
            end
        end

        if (clear) begin
            sw_d   = '0;
            sat_d  = 1'b0;
            pend_d = '0;
        end

        gt99_d = (sw_d > COUNT_W'(DISPLAY_MAX));
        upd_d  = (sw_d != sw_q);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            sw_q   <= '0;
            sat_q  <= 1'b0;
            gt99_q <= 1'b0;
            upd_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            sw_q   <= sw_d;
            sat_q  <= sat_d;
            gt99_q <= gt99_d;
            upd_q  <= upd_d;
        end
    end

    assign SW   = sw_q;
    assign gt99 = gt99_q;
    assign sat  = sat_q;
    assign upd  = upd_q;

endmodule

// File: tb/tb_coin_tally.sv
// Self-checking bench for coin_tally: scoreboard of expected SW values popped on each upd pulse.
module tb_coin_tally;

    localparam int DEB_CYCLES = 16;
`ifdef COIN_TALLY_DEBOUNCE_EN
    localparam int DEB = DEB_CYCLES;
`else
    localparam int DEB = 0;
`endif
    localparam int LAT = 4 + DEB;
    localparam int PW  = DEB + 4;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic       clear    = 1'b0;
    logic [3:0] coin_in  = 4'b0000;
    logic [6:0] SW;
    logic       gt99;
    logic       sat;
    logic       upd;

    always #5 CLOCK_50 = ~CLOCK_50;

    coin_tally #(
        .DEBOUNCE_CYCLES(DEB_CYCLES)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .coin_in  (coin_in),
        .clear    (clear),
        .SW       (SW),
        .gt99     (gt99),
        .sat      (sat),
        .upd      (upd)
    );

    int n_chk   = 0;
    int n_fail  = 0;
    int upd_cnt = 0;
    bit mon_en  = 1'b0;
    int exp_q[$];

    always @(negedge CLOCK_50) begin
        int e;
        if (mon_en && upd === 1'b1) begin
            upd_cnt++;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_upd: SW=%0d, no update was expected", SW);
            end else begin
                e = exp_q.pop_front();
                if (SW !== 7'(e)) begin
                    n_fail++;
                    $display("FAIL sb_sw: SW=%0d, required %0d", SW, e);
                end
                n_chk++;
                if (gt99 !== (e > 99)) begin
                    n_fail++;
                    $display("FAIL sb_gt99: gt99=%b, required %b (SW %0d)", gt99, (e > 99), e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic pulse(input logic [3:0] mask);
        coin_in = coin_in | mask;
        step(PW);
        coin_in = coin_in & ~mask;
        step(PW);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            step(1);
            k++;
        end
        step(2);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected updates outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        step(2);
        n_chk++; if (SW !== 7'd0)  begin n_fail++; $display("FAIL reset_sw: SW=%0d, required 0", SW); end
        n_chk++; if (gt99 !== 1'b0) begin n_fail++; $display("FAIL reset_gt99: gt99=%b, required 0", gt99); end
        n_chk++; if (sat !== 1'b0)  begin n_fail++; $display("FAIL reset_sat: sat=%b, required 0", sat); end
        n_chk++; if (upd !== 1'b0)  begin n_fail++; $display("FAIL reset_upd: upd=%b, required 0", upd); end
        reset = 1'b0;
        step(2);
        mon_en = 1'b1;
    endtask

    task automatic test_two_coins();
        int u0 = upd_cnt;
        exp_q.push_back(25);
        coin_in[3] = 1'b1;
        step(LAT - 1);
        n_chk++; if (SW !== 7'd0) begin n_fail++; $display("FAIL latency_early: SW=%0d, required 0", SW); end
        step(1);
        n_chk++; if (SW !== 7'd25) begin n_fail++; $display("FAIL latency_sw: SW=%0d, required 25", SW); end
        n_chk++; if (upd !== 1'b1) begin n_fail++; $display("FAIL latency_upd: upd=%b, required 1", upd); end
        coin_in[3] = 1'b0;
        step(PW);
        exp_q.push_back(35);
        pulse(4'b0100);
        drain();
        n_chk++; if (SW !== 7'd35) begin n_fail++; $display("FAIL two_sw: SW=%0d, required 35", SW); end
        n_chk++; if (gt99 !== 1'b0) begin n_fail++; $display("FAIL two_gt99: gt99=%b, required 0", gt99); end
        n_chk++;
        if (upd_cnt - u0 !== 2) begin
            n_fail++;
            $display("FAIL two_upd_count: %0d pulses, required 2", upd_cnt - u0);
        end
    endtask

    task automatic test_simultaneous();
        int want[4] = '{25, 35, 40, 41};
        exp_q.push_back(0);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        foreach (want[i]) exp_q.push_back(want[i]);
        coin_in = 4'b1111;
        step(LAT - 1);
        for (int i = 0; i < 4; i++) begin
            step(1);
            n_chk++;
            if (SW !== 7'(want[i])) begin
                n_fail++;
                $display("FAIL simul_sw%0d: SW=%0d, required %0d", i, SW, want[i]);
            end
            n_chk++;
            if (upd !== 1'b1) begin
                n_fail++;
                $display("FAIL simul_upd%0d: upd=%b, required 1", i, upd);
            end
        end
        coin_in = 4'b0000;
        step(PW);
        drain();
    endtask

    task automatic test_saturation();
        int u0;
        exp_q.push_back(0);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        for (int q = 1; q <= 4; q++) begin
            exp_q.push_back(q * 25);
            pulse(4'b1000);
        end
        drain();
        n_chk++; if (SW !== 7'd100) begin n_fail++; $display("FAIL sat_sw100: SW=%0d, required 100", SW); end
        n_chk++; if (gt99 !== 1'b1) begin n_fail++; $display("FAIL sat_gt99: gt99=%b, required 1", gt99); end
        exp_q.push_back(125);
        pulse(4'b1000);
        drain();
        n_chk++; if (sat !== 1'b0) begin n_fail++; $display("FAIL sat_early: sat=%b, required 0 at SW=125", sat); end
        exp_q.push_back(127);
        pulse(4'b0010);
        drain();
        n_chk++; if (SW !== 7'd127) begin n_fail++; $display("FAIL sat_sw127: SW=%0d, required 127", SW); end
        n_chk++; if (sat !== 1'b1) begin n_fail++; $display("FAIL sat_set: sat=%b, required 1", sat); end
        u0 = upd_cnt;
        pulse(4'b0001);
        step(4);
        n_chk++; if (SW !== 7'd127) begin n_fail++; $display("FAIL sat_hold: SW=%0d, required 127", SW); end
        n_chk++; if (sat !== 1'b1) begin n_fail++; $display("FAIL sat_sticky: sat=%b, required 1", sat); end
        n_chk++;
        if (upd_cnt !== u0) begin
            n_fail++;
            $display("FAIL sat_no_upd: %0d pulses, required 0", upd_cnt - u0);
        end
    endtask

    task automatic test_clear_race();
        exp_q.push_back(0);
        coin_in[2] = 1'b1;
        step(LAT - 2);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        n_chk++; if (SW !== 7'd0) begin n_fail++; $display("FAIL race_sw: SW=%0d, required 0", SW); end
        n_chk++; if (sat !== 1'b0) begin n_fail++; $display("FAIL race_sat: sat=%b, required 0", sat); end
        step(PW);
        coin_in[2] = 1'b0;
        step(PW);
        n_chk++; if (SW !== 7'd0) begin n_fail++; $display("FAIL race_dime_lost: SW=%0d, required 0", SW); end
        drain();
    endtask

    task automatic test_reset_mid();
        int u0;
        exp_q.push_back(25);
        pulse(4'b1000);
        drain();
        mon_en = 1'b0;
        coin_in = 4'b0111;
        step(LAT);
        n_chk++; if (SW !== 7'd35) begin n_fail++; $display("FAIL mid_pre_sw: SW=%0d, required 35", SW); end
        #2 reset = 1'b1;
        #1;
        n_chk++; if (SW !== 7'd0)   begin n_fail++; $display("FAIL mid_sw: SW=%0d, required 0", SW); end
        n_chk++; if (gt99 !== 1'b0) begin n_fail++; $display("FAIL mid_gt99: gt99=%b, required 0", gt99); end
        n_chk++; if (sat !== 1'b0)  begin n_fail++; $display("FAIL mid_sat: sat=%b, required 0", sat); end
        n_chk++; if (upd !== 1'b0)  begin n_fail++; $display("FAIL mid_upd: upd=%b, required 0", upd); end
        coin_in = 4'b0001;
        step(3);
        u0 = upd_cnt;
        exp_q.push_back(1);
        mon_en = 1'b1;
        reset = 1'b0;
        drain();
        step(PW);
        coin_in = 4'b0000;
        step(PW);
        n_chk++; if (SW !== 7'd1) begin n_fail++; $display("FAIL mid_once_sw: SW=%0d, required 1", SW); end
        n_chk++;
        if (upd_cnt - u0 !== 1) begin
            n_fail++;
            $display("FAIL mid_once_upd: %0d pulses, required 1", upd_cnt - u0);
        end
    endtask

`ifdef COIN_TALLY_DEBOUNCE_EN
    task automatic test_debounce();
        int u0 = upd_cnt;
        coin_in[0] = 1'b1;
        step(8);
        coin_in[0] = 1'b0;
        step(30);
        n_chk++; if (SW !== 7'd1) begin n_fail++; $display("FAIL deb_glitch_sw: SW=%0d, required 1", SW); end
        n_chk++;
        if (upd_cnt !== u0) begin
            n_fail++;
            $display("FAIL deb_glitch_upd: %0d pulses, required 0", upd_cnt - u0);
        end
        exp_q.push_back(2);
        coin_in[0] = 1'b1;
        step(LAT - 1);
        n_chk++; if (SW !== 7'd1) begin n_fail++; $display("FAIL deb_early: SW=%0d, required 1", SW); end
        step(1);
        n_chk++; if (SW !== 7'd2) begin n_fail++; $display("FAIL deb_press: SW=%0d, required 2", SW); end
        coin_in[0] = 1'b0;
        step(PW);
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_two_coins();
        test_simultaneous();
        test_saturation();
        test_clear_race();
        test_reset_mid();
`ifdef COIN_TALLY_DEBOUNCE_EN
        test_debounce();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
